serie_paralelo: RTL and testbench

SERIE_PARALELO -- requirements
Module: serie_paralelo

---
 rtl/serie_paralelo.sv | 106 ++++++++++
 tb/tb_serie_paralelo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/serie_paralelo.sv
// serie_paralelo: serial-to-parallel receiver with comma (BC) alignment.
//
// Finds symbol alignment by sliding a bit-level search for BC_SYMBOL, then
// confirms it with BC_LOCK consecutive aligned BC symbols before locking.
// Once locked, each completed non-BC symbol is presented on data_out with a
// one-cycle valid_out strobe. BC symbols seen while locked are counted.
//
// Ports
//   clock32   in   bit-rate clock, rising edge
//   reset     in   asynchronous, active-high reset
//   data_in   in   serial stream, MSB of each symbol first
//   data_out  out  [7:0]  last received non-BC byte (held)
//   valid_out out  one-cycle strobe, data_out updated this cycle
//   active    out  link locked
//   counterBC out  [15:0] BC symbols received while locked (wraps)
module serie_paralelo #(
  parameter logic [7:0] BC_SYMBOL = 8'hBC,
  parameter int         BC_LOCK   = 4
) (
  input  logic        clock32,
  input  logic        reset,
  input  logic        data_in,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        active,
  output logic [15:0] counterBC
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] LOCK_N = 4'(BC_LOCK);

  state_t      state;
  logic [7:0]  sr;
  logic [7:0]  nb;
  logic [2:0]  bit_cnt;
  logic [3:0]  bc_cnt;
  logic        boundary;
  logic        nb_is_bc;

  // Symbol including the bit arriving this cycle.
  assign nb       = {sr[6:0], data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign nb_is_bc = (nb == BC_SYMBOL);

  always_ff @(posedge clock32 or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      sr        <= '0;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
      counterBC <= '0;
    end else begin
      sr        <= nb;
      valid_out <= 1'b0;
      case (state)
        SEARCH: begin
          // Sliding match: any bit position may start a symbol.
          if (nb_is_bc) begin
            bit_cnt <= '0;
            bc_cnt  <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state  <= ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ALIGN;
            end
          end
        end
        ALIGN: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (nb_is_bc) begin
              bc_cnt <= bc_cnt + 4'd1;
              if (bc_cnt + 4'd1 == LOCK_N) begin
                state  <= ACTIVE;
                active <= 1'b1;
              end
            end else begin
              // Alignment broken; resume sliding search on the next bit.
              state   <= SEARCH;
              bc_cnt  <= '0;
              bit_cnt <= '0;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 3'd1;
          if (boundary) begin
            if (nb_is_bc) begin
              counterBC <= counterBC + 16'd1;
            end else begin
              data_out  <= nb;
              valid_out <= 1'b1;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_serie_paralelo.sv
// Directed bench for serie_paralelo: alignment, lock, data strobes, BC
// counting and wrap, and asynchronous reset in the middle of a byte.
module tb_serie_paralelo;

  logic        clock32;
  logic        reset;
  logic        data_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        active;
  logic [15:0] counterBC;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [7:0] BC = 8'hBC;

  serie_paralelo #(.BC_SYMBOL(8'hBC), .BC_LOCK(4)) dut (
    .clock32  (clock32),
    .reset    (reset),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .active   (active),
    .counterBC(counterBC)
  );

  initial clock32 = 1'b0;
  always #5 clock32 = ~clock32;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one bit, let the rising edge sample it, then settle past the edge.
  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clock32);
    #1;
  endtask

  // Send bits hi..lo of b (MSB-first order).
  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 7, 0);
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b1;
    data_in = 1'b0;
    repeat (2) @(posedge clock32);
    #1;
    chk({tag, "_rst_data"},   32'(data_out),  32'h0);
    chk({tag, "_rst_valid"},  32'(valid_out), 32'h0);
    chk({tag, "_rst_active"}, 32'(active),    32'h0);
    chk({tag, "_rst_cnt"},    32'(counterBC), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    data_in = 1'b0;

    // Basic lock at edge 32, first byte at edge 40.
    do_reset("t1");
    repeat (3) send_byte(BC);
    send_bits(BC, 7, 1);
    chk("t1_active_e31", 32'(active), 32'h0);
    send_bits(BC, 0, 0);
    chk("t1_active_e32", 32'(active), 32'h1);
    chk("t1_cnt_lock",   32'(counterBC), 32'h0);
    send_bits(8'hA5, 7, 1);
    chk("t1_valid_e39",  32'(valid_out), 32'h0);
    send_bits(8'hA5, 0, 0);
    chk("t1_valid_e40",  32'(valid_out), 32'h1);
    chk("t1_data_e40",   32'(data_out),  32'hA5);

    // Data / BC interleave while locked.
    send_bits(8'h11, 7, 7);
    chk("t4_valid_once", 32'(valid_out), 32'h0);
    send_bits(8'h11, 6, 0);
    chk("t4_valid_11",   32'(valid_out), 32'h1);
    chk("t4_data_11",    32'(data_out),  32'h11);
    send_byte(BC);
    chk("t4_valid_bc1",  32'(valid_out), 32'h0);
    chk("t4_data_bc1",   32'(data_out),  32'h11);
    chk("t4_cnt_bc1",    32'(counterBC), 32'h1);
    send_byte(BC);
    chk("t4_data_bc2",   32'(data_out),  32'h11);
    chk("t4_cnt_bc2",    32'(counterBC), 32'h2);
    send_byte(8'h22);
    chk("t4_valid_22",   32'(valid_out), 32'h1);
    chk("t4_data_22",    32'(data_out),  32'h22);
    chk("t4_cnt_22",     32'(counterBC), 32'h2);

    // Counter wrap: preload the top count, then one more BC.
    force dut.counterBC = 16'hFFFF;
    send_bits(BC, 7, 4);
    release dut.counterBC;
    send_bits(BC, 3, 1);
    chk("t5_cnt_max",    32'(counterBC), 32'hFFFF);
    send_bits(BC, 0, 0);
    chk("t5_cnt_wrap",   32'(counterBC), 32'h0);
    chk("t5_active",     32'(active),    32'h1);

    // Reset three bits into a data byte: outputs clear without a clock edge.
    send_bits(8'h5A, 7, 5);
    reset = 1'b1;
    #2;
    chk("t6_async_data",   32'(data_out),  32'h0);
    chk("t6_async_active", 32'(active),    32'h0);
    chk("t6_async_cnt",    32'(counterBC), 32'h0);
    chk("t6_async_valid",  32'(valid_out), 32'h0);
    @(posedge clock32);
    #1;
    reset = 1'b0;
    repeat (3) send_byte(BC);
    send_bits(BC, 7, 1);
    chk("t6_relock_e31", 32'(active), 32'h0);
    send_bits(BC, 0, 0);
    chk("t6_relock_e32", 32'(active), 32'h1);

    // Three junk bits: bit-level alignment, lock at edge 35.
    do_reset("t2");
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    repeat (3) send_byte(BC);
    send_bits(BC, 7, 1);
    chk("t2_active_e34", 32'(active), 32'h0);
    send_bits(BC, 0, 0);
    chk("t2_active_e35", 32'(active), 32'h1);
    send_byte(8'h3C);
    chk("t2_valid_e43",  32'(valid_out), 32'h1);
    chk("t2_data_e43",   32'(data_out),  32'h3C);

    // Broken alignment returns to search; lock only after 4 fresh BCs.
    do_reset("t3");
    send_byte(BC);
    send_byte(BC);
    send_byte(8'h00);
    chk("t3_active_00",  32'(active),    32'h0);
    chk("t3_valid_00",   32'(valid_out), 32'h0);
    repeat (3) send_byte(BC);
    send_bits(BC, 7, 1);
    chk("t3_active_e55", 32'(active), 32'h0);
    send_bits(BC, 0, 0);
    chk("t3_active_e56", 32'(active), 32'h1);
    send_byte(8'h7E);
    chk("t3_valid_7e",   32'(valid_out), 32'h1);
    chk("t3_data_7e",    32'(data_out),  32'h7E);
    chk("t3_cnt_7e",     32'(counterBC), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
